// File: rtl/alu_issue_queue.sv
// Issue stage in front of the fixed-latency 16-bit ALU: operand FIFO -> registered ALU inputs,
// in-flight valid pipe, and an in-order result FIFO guarded by a credit check.
module alu_issue_queue #(
    parameter int DATA_W  = 16,
    parameter int OP_W    = 2,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + DATA_W + OP_W;
    localparam int CW = $clog2(DEPTH + ALU_LAT + 2) + 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [EW-1:0]     op_mem  [DEPTH];
    logic [DATA_W-1:0] res_mem [DEPTH];
    logic [AW:0]       op_wr, op_rd, res_wr, res_rd, res_count;
    logic [ALU_LAT:0]  vpipe;
    logic [CW-1:0]     inflight;
    logic [EW-1:0]     op_head;
    logic op_full, op_empty, res_empty;
    logic push, issue, capture, pop;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready never depends on the same-cycle valid, and valid never waits on ready.
    assign op_empty  = (op_wr == op_rd);
    assign op_full   = (op_wr[AW] != op_rd[AW]) && (op_wr[AW-1:0] == op_rd[AW-1:0]);
    assign res_empty = (res_wr == res_rd);
    assign res_count = res_wr - res_rd;

    assign in_ready  = !op_full;
    assign out_valid = !res_empty;
    assign out_result = out_valid ? res_mem[res_rd[AW-1:0]] : '0;
    assign op_head   = op_mem[op_rd[AW-1:0]];

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign capture = vpipe[ALU_LAT];

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
    end

    // Credit: every op in flight already owns a result-FIFO slot, so capture can never overflow.
    assign issue = !op_empty && ((CW'(res_count) + inflight) < CW'(DEPTH));

    assign busy = !op_empty || (|vpipe) || !res_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_wr  <= '0;
            op_rd  <= '0;
            res_wr <= '0;
            res_rd <= '0;
            vpipe  <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else begin
            if (push) op_wr <= op_wr + PTR_ONE;
            if (issue) begin
                op_rd  <= op_rd + PTR_ONE;
                alu_a  <= op_head[DATA_W-1:0];
                alu_b  <= op_head[2*DATA_W-1:DATA_W];
                alu_op <= op_head[EW-1:2*DATA_W];
            end
            vpipe[0] <= issue;
            for (int i = 1; i <= ALU_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            if (capture) res_wr <= res_wr + PTR_ONE;
            if (pop)     res_rd <= res_rd + PTR_ONE;
        end
    end

    // Storage arrays carry no reset; their contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (push)    op_mem[op_wr[AW-1:0]]   <= {in_op, in_b, in_a};
        if (capture) res_mem[res_wr[AW-1:0]] <= alu_result;
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: adder ALU stub, expected-result queue fed by accepted pushes,
// directed latency/throughput/backpressure/reset scenarios plus a randomized run.
module tb_alu_issue_queue;

    localparam int DATA_W  = 16;
    localparam int OP_W    = 2;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic              clk;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              busy;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] last_pop;
    int n_checks;
    int n_fail;
    int n_pops;

    alu_issue_queue #(
        .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-stage adder standing in for the ALU
    always_ff @(posedge clk) alu_q <= alu_a + alu_b;
    assign alu_result = alu_q;

    // Scoreboard: every accepted operand pair owes exactly one sum, returned in order.
    always @(negedge clk) begin
        logic [DATA_W-1:0] s;
        if (!resetn) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: out_result=%h popped, nothing expected", out_result);
                end else begin
                    if (out_result !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL sb_data: out_result=%h expected %h", out_result, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                n_pops++;
                last_pop = out_result;
            end
            if (in_valid && in_ready) begin
                s = in_a + in_b;
                exp_q.push_back(s);
            end
        end
    end

    // Driver tasks
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_result !== 16'h0) begin n_fail++; $display("FAIL rst_out_result: got %h want 0", out_result); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (alu_a !== 16'h0) begin n_fail++; $display("FAIL rst_alu_a: got %h want 0", alu_a); end
        if (alu_b !== 16'h0) begin n_fail++; $display("FAIL rst_alu_b: got %h want 0", alu_b); end
        if (alu_op !== 2'h0) begin n_fail++; $display("FAIL rst_alu_op: got %h want 0", alu_op); end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_single_op();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'd3; in_b = 16'd4; in_op = 2'd2;
        @(posedge clk);  // edge 1: push
        #2;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e1_valid: got %b want 0", out_valid); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_e1_busy: got %b want 1", busy); end
        @(negedge clk);  // after edge 2: issued
        n_checks += 3;
        if (alu_a !== 16'd3) begin n_fail++; $display("FAIL single_alu_a: got %h want 3", alu_a); end
        if (alu_b !== 16'd4) begin n_fail++; $display("FAIL single_alu_b: got %h want 4", alu_b); end
        if (alu_op !== 2'd2) begin n_fail++; $display("FAIL single_alu_op: got %h want 2", alu_op); end
        @(negedge clk);  // after edge 3
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e3_valid: got %b want 0", out_valid); end
        @(negedge clk);  // after edge 4: captured
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_e4_valid: got %b want 1", out_valid); end
        if (out_result !== 16'd7) begin n_fail++; $display("FAIL single_result: got %h want 7", out_result); end
        @(negedge clk);  // after edge 5: popped
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e5_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_e5_busy: got %b want 0", busy); end
        @(posedge clk);
        #2;
    endtask

    task automatic test_streaming();
        int pops0;
        bit ok;
        pops0 = n_pops;
        out_ready = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            in_valid = (k < 16);
            in_a = 16'(k); in_b = 16'd100; in_op = 2'(k);
            @(negedge clk);  // state after edge k; pushes land on edges 1..16
            n_checks++;
            if (out_valid !== ((k >= 4) && (k <= 19))) begin
                n_fail++;
                $display("FAIL stream_valid: k=%0d got %b want %b", k, out_valid, (k >= 4) && (k <= 19));
            end
            if (k < 16) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: k=%0d got 0 want 1", k); end
            end
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL stream_drain: busy still 1 after bound"); end
        if (n_pops - pops0 != 16) begin n_fail++; $display("FAIL stream_count: got %0d results want 16", n_pops - pops0); end
    endtask

    task automatic test_backpressure();
        int idx;
        int pops0;
        bit acc;
        bit ok;
        idx = 0;
        pops0 = n_pops;
        out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (idx < 10);
            in_a = 16'(200 + idx); in_b = 16'(idx * 3); in_op = 2'(idx);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #2;
            if (acc) idx++;
        end
        n_checks += 5;
        if (idx != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", idx); end
        if (exp_q.size() != 8) begin n_fail++; $display("FAIL bp_outstanding: got %0d want 8", exp_q.size()); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        if (n_pops != pops0) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops want 0", n_pops - pops0); end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            in_valid = 1'b1;
            in_a = 16'(200 + idx); in_b = 16'(idx * 3); in_op = 2'(idx);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #2;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: busy still 1 after bound"); end
        if (n_pops - pops0 != 10) begin n_fail++; $display("FAIL bp_count: got %0d results want 10", n_pops - pops0); end
    endtask

    task automatic test_wrap();
        bit ok;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0002; in_op = 2'd1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL wrap_drain: busy still 1 after bound"); end
        if (last_pop !== 16'h0001) begin n_fail++; $display("FAIL wrap_result: got %h want 0001", last_pop); end
    endtask

    task automatic test_random();
        bit ok;
        for (int c = 0; c < 300; c++) begin
            // busy must reflect exactly whether any accepted op is still owed
            n_checks++;
            if (busy !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_busy: c=%0d got %b outstanding %0d", c, busy, exp_q.size());
            end
            if (in_ready === 1'b0) begin
                n_checks++;
                if (exp_q.size() < DEPTH) begin
                    n_fail++;
                    $display("FAIL rand_in_ready: c=%0d low with only %0d outstanding", c, exp_q.size());
                end
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = 16'($urandom); in_b = 16'($urandom); in_op = 2'($urandom_range(0, 3));
            if ((c % 60) < 30) out_ready = ($urandom_range(0, 3) == 0);
            else               out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL rand_drain: busy still 1 after bound"); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: %0d results never returned", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        int pops0;
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'(50 + i); in_b = 16'd7; in_op = 2'd3;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks += 7;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
        if (out_result !== 16'h0) begin n_fail++; $display("FAIL mrst_out_result: got %h want 0", out_result); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b want 0", busy); end
        if (alu_a !== 16'h0) begin n_fail++; $display("FAIL mrst_alu_a: got %h want 0", alu_a); end
        if (alu_b !== 16'h0) begin n_fail++; $display("FAIL mrst_alu_b: got %h want 0", alu_b); end
        if (alu_op !== 2'h0) begin n_fail++; $display("FAIL mrst_alu_op: got %h want 0", alu_op); end
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #2;
        pops0 = n_pops;
        in_valid = 1'b1; in_a = 16'd1; in_b = 16'd1; in_op = 2'd0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        wait_idle(ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL mrst_drain: busy still 1 after bound"); end
        if (n_pops - pops0 != 1) begin n_fail++; $display("FAIL mrst_count: got %0d results want 1", n_pops - pops0); end
        if (last_pop !== 16'd2) begin n_fail++; $display("FAIL mrst_result: got %h want 0002", last_pop); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_pops = 0;
        last_pop = '0;
        resetn = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_op();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Final report if something stalls the sequence
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: sequence did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
